// File: rtl/apb_burst_master_if.sv
// apb_burst_master_if: 8-bit APB bus between the burst master and a byte-wide memory slave.
interface apb_burst_master_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_burst_master.sv
// apb_burst_master: sequences 1..MAX_BYTES byte transfers per request at consecutive APB addresses.
// Defining APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait states.
module apb_burst_master #(
  parameter int ADDR_W         = 16,
  parameter int MAX_BYTES      = 3,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int LEN_W         = $clog2(MAX_BYTES + 1)
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   we,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic [1:0]             err_code,
  apb_burst_master_if.master     apb
);
  localparam int RW = 8 * MAX_BYTES;
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3;
  localparam logic [LEN_W-1:0] MAXB = LEN_W'(MAX_BYTES);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [7:0]        pwdata_q, pwdata_d;
  logic [RW-1:0]     wbuf_q, wbuf_d, rdata_q, rdata_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        err_q, err_d;
  logic              busy_q, busy_d, done_q, done_d, psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [LEN_W-1:0]  n;
  logic [RW-1:0]     wshift;
  logic              expired;
  assign n = (len > MAXB) ? MAXB : len;
  // Left-align the used write bytes so each transfer takes the top byte.
  assign wshift = wdata << {MAXB - n, 3'b000};
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign expired = state_q == ACCESS && !apb.pready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    wbuf_d    = wbuf_q;
    rdata_d   = rdata_q;
    rem_d     = rem_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    case (state_q)
      IDLE: if (req) begin
        busy_d   = 1'b1;
        err_d    = 2'b00;
        pwrite_d = we;
        if (!we || n == '0) rdata_d = '0;
        if (n == '0) state_d = DONE;
        else begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          paddr_d  = addr;
          pwdata_d = wshift[RW-1 -: 8];
          wbuf_d   = wshift << 8;
          rem_d    = n;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: if (apb.pready && apb.pslverr) begin
        err_d     = 2'b01;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = DONE;
      end else if (apb.pready) begin
        penable_d = 1'b0;
        if (!pwrite_q) rdata_d = (rdata_q << 8) | RW'(apb.prdata);
        if (rem_q == LEN_W'(1)) begin
          psel_d  = 1'b0;
          state_d = DONE;
        end else begin
          state_d  = SETUP;
          paddr_d  = paddr_q + ADDR_W'(1);
          pwdata_d = wbuf_q[RW-1 -: 8];
          wbuf_d   = wbuf_q << 8;
          rem_d    = rem_q - LEN_W'(1);
        end
      end else if (expired) begin
        err_d     = 2'b10;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = DONE;
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      wbuf_q    <= '0;
      rdata_q   <= '0;
      rem_q     <= '0;
      err_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      wbuf_q    <= wbuf_d;
      rdata_q   <= rdata_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
    end
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign err_code    = err_q;
  assign apb.paddr   = paddr_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
endmodule

// File: tb/tb_apb_burst_master.sv
// tb_apb_burst_master: directed and random bursts against a byte-memory slave and a transaction-level model.
module tb_apb_burst_master;
  localparam int AW = 16, MB = 3, LW = $clog2(MB + 1), RW = 8 * MB;
  logic sysclk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] len = '0;
  logic [RW-1:0] wdata = '0;
  logic busy, done;
  logic [RW-1:0] rdata;
  logic [1:0] err_code;
  apb_burst_master_if #(.ADDR_W(AW)) apb();
  apb_burst_master #(.ADDR_W(AW), .MAX_BYTES(MB), .TIMEOUT_CYCLES(16)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .req(req), .addr(addr), .we(we), .len(len), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err_code(err_code), .apb(apb)
  );
  always #5 sysclk = ~sysclk;
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] init_b(input int a);
    return 8'((a * 37) ^ (a >> 5) ^ 8'h5a);
  endfunction
  logic [7:0] smem [int];
  logic [7:0] rmem [int];
  logic [AW-1:0] log_a [int];
  logic          log_w [int];
  logic [7:0]    log_d [int];
  int nt = 0, ws = 0, err_at = -1, prot_err = 0, waited = 0;
  logic [AW-1:0] s_a;
  logic s_w;
  logic [7:0] s_d;
  logic [RW-1:0] prev_rdata = '0;
  // Slave: waits ws cycles per ACCESS, logs each completed transfer, flags protocol violations.
  always @(negedge sysclk) begin
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    if (apb.penable && !apb.psel) prot_err++;
    if (apb.psel && !apb.penable) begin
      s_a = apb.paddr; s_w = apb.pwrite; s_d = apb.pwdata; waited = 0;
    end
    if (apb.psel && apb.penable) begin
      if (apb.paddr !== s_a || apb.pwrite !== s_w || apb.pwdata !== s_d) prot_err++;
      if (waited < ws) waited++;
      else begin
        apb.pready  = 1'b1;
        apb.pslverr = (nt == err_at);
        apb.prdata  = smem.exists(int'(apb.paddr)) ? smem[int'(apb.paddr)] : init_b(int'(apb.paddr));
        log_a[nt] = apb.paddr; log_w[nt] = apb.pwrite; log_d[nt] = apb.pwdata;
        if (apb.pwrite && !apb.pslverr) smem[int'(apb.paddr)] = apb.pwdata;
        nt++;
      end
    end
  end
  // mode 0: normal, 1: reset during ACCESS of byte 2, 2: pready stuck low
  task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] l,
                        input logic [RW-1:0] d, input int wsi, input int ei, input int mode);
    int n, base, nx, ok, lat, exp_lat, exp_err;
    bit seen;
    logic [RW-1:0] er;
    logic [AW-1:0] ea;
    n = (int'(l) > MB) ? MB : int'(l);
    ws = wsi; base = nt; err_at = (ei >= 0) ? base + ei : -1;
    addr = a; we = w; len = l; wdata = d; req = 1'b1;
    @(posedge sysclk); #1;
    req = 1'b0; addr = AW'($urandom); we = 1'($urandom); len = LW'($urandom); wdata = RW'($urandom);
    chk("busy_accept", busy, 1);
    lat = 0; seen = 0;
    while (lat < ((mode == 2) ? 100 : 400) && !seen) begin
      @(posedge sysclk); lat++;
      @(negedge sysclk); #1;
      seen = done;
      if (mode == 0 && n >= 2 && lat == 2) req = 1'b1;
      if (lat == 3) req = 1'b0;
      if (mode == 1 && nt - base == 1 && apb.psel && apb.penable) begin
        rst_n = 1'b0; #1;
        chk("rst_psel", apb.psel, 0); chk("rst_penable", apb.penable, 0);
        chk("rst_busy", busy, 0); chk("rst_rdata", rdata, 0);
        repeat (3) begin @(negedge sysclk); chk("rst_no_done", done, 0); end
        #1 rst_n = 1'b1;
        prev_rdata = '0;
        return;
      end
    end
`ifndef APB_TIMEOUT_EN
    if (mode == 2) begin
      chk("stuck_no_done", seen, 0); chk("stuck_busy", busy, 1); chk("stuck_err", err_code, 0);
      rst_n = 1'b0; #2 rst_n = 1'b1;
      prev_rdata = '0; ws = 0;
      @(negedge sysclk); #1;
      return;
    end
`endif
    nx = (ei >= 0) ? ei + 1 : n;
    ok = (ei >= 0) ? ei : n;
    exp_err = (ei >= 0) ? 1 : 0;
    exp_lat = 2 * nx + 1 + wsi * nx;
    if (mode == 2) begin nx = 0; ok = 0; exp_err = 2; exp_lat = 18; end
    chk("done_seen", seen, 1);
    chk("latency", lat, exp_lat);
    chk("busy_at_done", busy, 0);
    chk("n_xfers", nt - base, nx);
    er = (w && n != 0) ? prev_rdata : '0;
    for (int i = 0; i < nx; i++) begin
      ea = a + AW'(i);
      chk("paddr", log_a[base + i], ea);
      chk("pwrite", log_w[base + i], w);
      if (w) chk("pwdata", log_d[base + i], d[8 * (n - 1 - i) +: 8]);
      if (i < ok) begin
        if (w) rmem[int'(ea)] = d[8 * (n - 1 - i) +: 8];
        else er = (er << 8) | RW'(rmem.exists(int'(ea)) ? rmem[int'(ea)] : init_b(int'(ea)));
      end
    end
    chk("rdata", rdata, er);
    chk("err_code", err_code, exp_err);
    prev_rdata = er;
    ws = 0;
    @(posedge sysclk); @(negedge sysclk); #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("rdata_hold", rdata, er);
  endtask
  initial begin
    int l, ei;
    repeat (2) @(negedge sysclk);
    #1;
    chk("rst_busy0", busy, 0); chk("rst_done0", done, 0); chk("rst_psel0", apb.psel, 0);
    chk("rst_pen0", apb.penable, 0); chk("rst_pwrite0", apb.pwrite, 0); chk("rst_paddr0", apb.paddr, 0);
    chk("rst_pwdata0", apb.pwdata, 0); chk("rst_rdata0", rdata, 0); chk("rst_err0", err_code, 0);
    rst_n = 1'b1;
    @(negedge sysclk); #1;
    do_req(16'h0405, 1'b1, 2'd3, 24'hABCDEF, 0, -1, 0);
    do_req(16'h0405, 1'b0, 2'd3, 24'h0, 0, -1, 0);
    do_req(16'h0406, 1'b0, 2'd1, 24'h0, 0, -1, 0);
    do_req(16'hFFFF, 1'b1, 2'd3, 24'h112233, 0, -1, 0);
    do_req(16'hFFFF, 1'b0, 2'd3, 24'h0, 0, -1, 0);
    do_req(16'h1234, 1'b0, 2'd0, 24'h0, 0, -1, 0);
    do_req(16'h0405, 1'b0, 2'd3, 24'h0, 4, -1, 0);
    do_req(16'h0405, 1'b0, 2'd3, 24'h0, 0, 1, 0);
    do_req(16'h0405, 1'b0, 2'd3, 24'h0, 2, -1, 1);
    do_req(16'h0405, 1'b0, 2'd3, 24'h0, 0, -1, 0);
    for (int k = 0; k < 40; k++) begin
      l  = $urandom_range(0, 3);
      ei = (l > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, l - 1) : -1;
      do_req(($urandom_range(0, 3) == 0) ? AW'(16'hFFFE + $urandom_range(0, 1)) : AW'(16'h0400 + $urandom_range(0, 15)),
             1'($urandom), LW'(l), RW'($urandom), $urandom_range(0, 2), ei, 0);
    end
    do_req(16'h0200, 1'b0, 2'd2, 24'h0, 100000, -1, 2);
    do_req(16'h0405, 1'b0, 2'd3, 24'h0, 0, -1, 0);
    chk("protocol", prot_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
